ysyx_220066_lsu: RTL

- Load/store unit between the core's single-cycle memory port (addr, data_Wr, MemRd, MemWr, MemOp) and a 64-bit valid/ready data bus.
- Sits directly downstream of the core's execute/memory stage.
- Aligns store data into byte lanes with a mask, issues one bus transaction, then extracts and sign/zero-extends load data.
- Stalls the core while the access is outstanding and flags misaligned or timed-out accesses.

---
 rtl/ysyx_220066_pkg.sv | 41 ++++
 rtl/ysyx_220066_lsu_align.sv | 56 +++++
 rtl/ysyx_220066_lsu.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/ysyx_220066_pkg.sv
// ysyx_220066_pkg
// Shared definitions for the load/store unit:
//   - RISC-V funct3 load/store encodings (MEMOP_B .. MEMOP_WU)
//   - LSU state enum (IDLE, REQ, WAIT, DONE)
//   - byte-lane size masks and a helper that maps an access size to its mask
package ysyx_220066_pkg;

    localparam logic [2:0] MEMOP_B  = 3'b000;
    localparam logic [2:0] MEMOP_H  = 3'b001;
    localparam logic [2:0] MEMOP_W  = 3'b010;
    localparam logic [2:0] MEMOP_D  = 3'b011;
    localparam logic [2:0] MEMOP_BU = 3'b100;
    localparam logic [2:0] MEMOP_HU = 3'b101;
    localparam logic [2:0] MEMOP_WU = 3'b110;

    localparam logic [7:0] MASK_B = 8'h01;
    localparam logic [7:0] MASK_H = 8'h03;
    localparam logic [7:0] MASK_W = 8'h0F;
    localparam logic [7:0] MASK_D = 8'hFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsu_state_e;

    // The low two funct3 bits encode the access size for both signed and
    // unsigned variants, so the mask only depends on them.
    function automatic logic [7:0] size_mask(input logic [1:0] size);
        logic [7:0] mask;
        case (size)
            2'b00:   mask = MASK_B;
            2'b01:   mask = MASK_H;
            2'b10:   mask = MASK_W;
            default: mask = MASK_D;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/ysyx_220066_lsu_align.sv
// ysyx_220066_lsu_align
// Purely combinational byte-lane steering for the LSU.
// Ports:
//   mem_op    in  3   funct3 of the access
//   offset    in  3   byte offset inside the 64-bit bus word (addr[2:0])
//   data_wr   in  64  right-justified store data
//   rdata     in  64  aligned 8-byte read data from the bus
//   wmask     out 8   byte-lane enables for the store
//   wdata     out 64  store data shifted into its lanes
//   load_data out 64  selected load bytes, sign/zero-extended
//   misalign  out 1   access crosses its natural alignment
//   bad_op    out 1   funct3 = 111 (no such load/store)
module ysyx_220066_lsu_align
    import ysyx_220066_pkg::*;
(
    input  logic [2:0]  mem_op,
    input  logic [2:0]  offset,
    input  logic [63:0] data_wr,
    input  logic [63:0] rdata,
    output logic [7:0]  wmask,
    output logic [63:0] wdata,
    output logic [63:0] load_data,
    output logic        misalign,
    output logic        bad_op
);

    logic [5:0]  shift_amt;
    logic [63:0] shifted;

    always_comb begin
        shift_amt = {offset, 3'b000};
        wmask     = size_mask(mem_op[1:0]) << offset;
        wdata     = data_wr << shift_amt;
        shifted   = rdata >> shift_amt;
        bad_op    = (mem_op == 3'b111);

        case (mem_op[1:0])
            2'b01:   misalign = offset[0];
            2'b10:   misalign = |offset[1:0];
            2'b11:   misalign = |offset;
            default: misalign = 1'b0;
        endcase

        case (mem_op)
            MEMOP_B:  load_data = {{56{shifted[7]}},  shifted[7:0]};
            MEMOP_H:  load_data = {{48{shifted[15]}}, shifted[15:0]};
            MEMOP_W:  load_data = {{32{shifted[31]}}, shifted[31:0]};
            MEMOP_D:  load_data = shifted;
            MEMOP_BU: load_data = {56'd0, shifted[7:0]};
            MEMOP_HU: load_data = {48'd0, shifted[15:0]};
            MEMOP_WU: load_data = {32'd0, shifted[31:0]};
            default:  load_data = 64'd0;
        endcase
    end

endmodule

// File: rtl/ysyx_220066_lsu.sv
// ysyx_220066_lsu
// Load/store unit bridging the core's single-cycle memory port to a 64-bit
// valid/ready bus. One bus transaction per access; the core is stalled
// while it is outstanding. Misaligned/illegal accesses and bus timeouts set
// a sticky error and complete with data_Rd = 0.
// Ports:
//   clk, rst                 clock (rising edge), async active-high reset
//   req_valid, MemRd, MemWr  core access request
//   MemOp, addr, data_Wr     funct3, byte address, right-justified store data
//   stall                    core must hold pc and inputs
//   data_Rd, resp_valid      extended load result, one-cycle completion pulse
//   error                    sticky fault flag
//   bus_req_valid/ready      bus request handshake
//   bus_we, bus_addr         write flag, 8-byte aligned address
//   bus_wmask, bus_wdata     byte-lane enables and lane-shifted store data
//   bus_rsp_valid, bus_rdata bus response and aligned read data
module ysyx_220066_lsu
    import ysyx_220066_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        MemRd,
    input  logic        MemWr,
    input  logic [2:0]  MemOp,
    input  logic [63:0] addr,
    input  logic [63:0] data_Wr,
    output logic        stall,
    output logic [63:0] data_Rd,
    output logic        resp_valid,
    output logic        error,
    output logic        bus_req_valid,
    input  logic        bus_req_ready,
    output logic        bus_we,
    output logic [63:0] bus_addr,
    output logic [7:0]  bus_wmask,
    output logic [63:0] bus_wdata,
    input  logic        bus_rsp_valid,
    input  logic [63:0] bus_rdata
);

    lsu_state_e  state;
    lsu_state_e  next_state;

    logic [2:0]  op_q;
    logic [2:0]  off_q;
    logic        we_q;
    logic [63:0] addr_q;
    logic [7:0]  wmask_q;
    logic [63:0] wdata_q;
    logic [63:0] data_rd_q;
    logic        error_q;
    logic [31:0] cnt_q;

    logic [2:0]  al_op;
    logic [2:0]  al_off;
    logic [7:0]  al_wmask;
    logic [63:0] al_wdata;
    logic [63:0] al_load;
    logic        al_misalign;
    logic        al_bad_op;

    logic        is_access;
    logic        is_good;
    logic        is_fault;
    logic        timed_out;

    // In IDLE the aligner looks at the live request so store lanes can be
    // latched; afterwards it uses the latched op/offset to extract the load.
    assign al_op  = (state == IDLE) ? MemOp     : op_q;
    assign al_off = (state == IDLE) ? addr[2:0] : off_q;

    ysyx_220066_lsu_align u_align (
        .mem_op    (al_op),
        .offset    (al_off),
        .data_wr   (data_Wr),
        .rdata     (bus_rdata),
        .wmask     (al_wmask),
        .wdata     (al_wdata),
        .load_data (al_load),
        .misalign  (al_misalign),
        .bad_op    (al_bad_op)
    );

    // Stores have no unsigned variants, so funct3[2] on a store is illegal.
    always_comb begin
        is_access = req_valid & (MemRd | MemWr);
        is_good   = is_access & (MemRd ^ MemWr) & ~al_misalign & ~al_bad_op
                    & ~(MemWr & MemOp[2]);
        is_fault  = is_access & ~is_good;
        timed_out = (TIMEOUT != 0) && (cnt_q == 32'(TIMEOUT - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Faulting requests skip the bus entirely and go straight to DONE.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (is_good) begin
                    next_state = REQ;
                end else if (is_fault) begin
                    next_state = DONE;
                end
            end
            REQ: begin
                if (bus_req_ready) begin
                    next_state = WAIT;
                end
            end
            WAIT: begin
                if (bus_rsp_valid || timed_out) begin
                    next_state = DONE;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        stall         = ((state == IDLE) && is_access) || (state == REQ) || (state == WAIT);
        bus_req_valid = (state == REQ);
        resp_valid    = (state == DONE);
        bus_we        = we_q;
        bus_addr      = addr_q;
        bus_wmask     = wmask_q;
        bus_wdata     = wdata_q;
        data_Rd       = data_rd_q;
        error         = error_q;
    end

    // Request latching, load capture, timeout counting and the sticky error.
    // A response wins over a timeout landing in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q      <= 3'd0;
            off_q     <= 3'd0;
            we_q      <= 1'b0;
            addr_q    <= 64'd0;
            wmask_q   <= 8'd0;
            wdata_q   <= 64'd0;
            data_rd_q <= 64'd0;
            error_q   <= 1'b0;
            cnt_q     <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    cnt_q <= 32'd0;
                    if (is_good) begin
                        op_q    <= MemOp;
                        off_q   <= addr[2:0];
                        we_q    <= MemWr;
                        addr_q  <= {addr[63:3], 3'b000};
                        wmask_q <= al_wmask;
                        wdata_q <= MemWr ? al_wdata : 64'd0;
                    end else if (is_fault) begin
                        error_q   <= 1'b1;
                        data_rd_q <= 64'd0;
                    end
                end
                WAIT: begin
                    if (bus_rsp_valid) begin
                        data_rd_q <= we_q ? 64'd0 : al_load;
                        cnt_q     <= 32'd0;
                    end else if (timed_out) begin
                        error_q   <= 1'b1;
                        data_rd_q <= 64'd0;
                        cnt_q     <= 32'd0;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                default: cnt_q <= 32'd0;
            endcase
        end
    end

endmodule
